up_cntr_arb: RTL and testbench

Round-robin scheduler that shares one W-bit up counter between NREQ requesters. Each requester asks for a timed run of len+1 counter cycles. The block grants the counter to one requester at a time and runs the count from 0 up to that requester's terminal value. It then pulses done back to the granted requester. It sits in front of the D-flip-flop up-counter datapath as its sequencing and sharing controller, and it owns the count register itself.

---
 rtl/up_cntr_arb.sv | 115 +++++++++++
 tb/tb_up_cntr_arb.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/up_cntr_arb.sv
// up_cntr_arb: round-robin arbiter sharing one W-bit up counter between NREQ requesters.
module up_cntr_arb #(
    parameter int NREQ = 4,
    parameter int W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] len,
    input  logic              hold,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic              abrt,
    output logic              busy,
    output logic [W-1:0]      Q
);
    localparam int PW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_n;
    logic [PW-1:0]   ptr, ptr_n, w, w_n, win, idx, nxt;
    logic [W-1:0]    tc, tc_n, q_n;
    logic [NREQ-1:0] gnt_n, done_n;
    logic            abrt_n, found;
    logic [W-1:0]    lens [NREQ];

    genvar i;
    for (i = 0; i < NREQ; i++) begin : g_len
        assign lens[i] = len[i*W +: W];
    end

    assign busy = (state != IDLE);
    assign nxt  = (w == PW'(NREQ-1)) ? '0 : w + 1'b1;

    always_comb begin
        win   = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = PW'((int'(ptr) + k) % NREQ);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        w_n     = w;
        tc_n    = tc;
        gnt_n   = gnt;
        done_n  = '0;
        abrt_n  = 1'b0;
        q_n     = Q;
        case (state)
            IDLE: begin
                q_n = '0;
                if (found) begin
                    w_n     = win;
                    gnt_n   = NREQ'(1) << win;
                    tc_n    = lens[win];
                    state_n = RUN;
                end
            end
            RUN: begin
                if (!req[w]) begin
                    gnt_n   = '0;
                    q_n     = '0;
                    abrt_n  = 1'b1;
                    ptr_n   = nxt;
                    state_n = IDLE;
                end else if (!hold) begin
                    if (Q == tc) begin
                        gnt_n   = '0;
                        done_n  = NREQ'(1) << w;
                        state_n = DONE;
                    end else begin
                        q_n = Q + 1'b1;
                    end
                end
            end
            DONE: begin
                q_n     = '0;
                ptr_n   = nxt;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            w     <= '0;
            tc    <= '0;
            gnt   <= '0;
            done  <= '0;
            abrt  <= 1'b0;
            Q     <= '0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            w     <= w_n;
            tc    <= tc_n;
            gnt   <= gnt_n;
            done  <= done_n;
            abrt  <= abrt_n;
            Q     <= q_n;
        end
    end
endmodule

// File: tb/tb_up_cntr_arb.sv
// tb_up_cntr_arb: directed self-checking bench for up_cntr_arb.
module tb_up_cntr_arb;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [15:0] len = '0;
    logic        hold = 1'b0;
    logic [3:0]  gnt, done, Q;
    logic        abrt, busy;
    int          n_cmp = 0;
    int          n_bad = 0;

    up_cntr_arb #(.NREQ(4), .W(4)) dut (
        .clk(clk), .rst(rst), .req(req), .len(len), .hold(hold),
        .gnt(gnt), .done(done), .abrt(abrt), .busy(busy), .Q(Q)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("gnt_onehot0", 32'($onehot0(gnt)), 1);
            chk("done_abrt_excl", 32'(|done & abrt), 0);
            chk("gnt_done_excl", 32'(|gnt & |done), 0);
        end
    end

    initial begin
        for (int i = 0; i < 5; i++) begin
            req = 4'($urandom);
            len = 16'($urandom);
            cyc();
            chk("rst_gnt", 32'(gnt), 0);
            chk("rst_done", 32'(done), 0);
            chk("rst_abrt", 32'(abrt), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_q", 32'(Q), 0);
        end
        rst = 1'b0;
        req = '0;
        cyc();
        cyc();
        chk("idle_gnt", 32'(gnt), 0);
        chk("idle_busy", 32'(busy), 0);

        len = 16'h0050;
        req = 4'b0010;
        for (int i = 0; i <= 5; i++) begin
            cyc();
            chk("single_gnt", 32'(gnt), 32'h2);
            chk("single_q", 32'(Q), i);
        end
        cyc();
        chk("single_done", 32'(done), 32'h2);
        chk("single_done_gnt", 32'(gnt), 0);
        chk("single_done_q", 32'(Q), 5);
        req = '0;
        cyc();
        chk("single_end_done", 32'(done), 0);
        chk("single_end_q", 32'(Q), 0);
        chk("single_end_busy", 32'(busy), 0);

        rst = 1'b1;
        cyc();
        rst = 1'b0;
        len = 16'h2222;
        req = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            cyc();
            chk("rr_gnt", 32'(gnt), 32'(4'b1 << (j % 4)));
            cyc();
            cyc();
            chk("rr_q", 32'(Q), 2);
            cyc();
            chk("rr_done", 32'(done), 32'(4'b1 << (j % 4)));
            cyc();
            chk("rr_idle", 32'(busy), 0);
        end
        req = '0;

        len = 16'h0000;
        req = 4'b0001;
        cyc();
        chk("tc0_gnt", 32'(gnt), 32'h1);
        chk("tc0_q", 32'(Q), 0);
        cyc();
        chk("tc0_done", 32'(done), 32'h1);
        req = '0;
        cyc();

        len = 16'hF000;
        req = 4'b1000;
        cyc();
        chk("max_q0", 32'(Q), 0);
        for (int i = 1; i <= 15; i++) begin
            cyc();
            chk("max_q", 32'(Q), i);
        end
        cyc();
        chk("max_done", 32'(done), 32'h8);
        chk("max_nowrap", 32'(Q), 15);
        req = '0;
        cyc();

        len = 16'h0009;
        req = 4'b0001;
        for (int i = 0; i <= 7; i++) cyc();
        chk("hold_q7", 32'(Q), 7);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("hold_q", 32'(Q), 7);
            chk("hold_gnt", 32'(gnt), 32'h1);
        end
        hold = 1'b0;
        cyc();
        chk("hold_q8", 32'(Q), 8);
        cyc();
        chk("hold_q9", 32'(Q), 9);
        chk("hold_nodone", 32'(done), 0);
        cyc();
        chk("hold_done", 32'(done), 32'h1);
        req = '0;
        cyc();

        len = 16'h0600;
        req = 4'b1100;
        cyc();
        chk("abrt_gnt2", 32'(gnt), 32'h4);
        for (int i = 0; i < 3; i++) cyc();
        chk("abrt_q3", 32'(Q), 3);
        req = 4'b1000;
        cyc();
        chk("abrt_pulse", 32'(abrt), 1);
        chk("abrt_gnt", 32'(gnt), 0);
        chk("abrt_q", 32'(Q), 0);
        chk("abrt_nodone", 32'(done), 0);
        cyc();
        chk("abrt_next_gnt", 32'(gnt), 32'h8);
        chk("abrt_clear", 32'(abrt), 0);
        cyc();
        chk("abrt_next_done", 32'(done), 32'h8);
        req = '0;
        cyc();

        len = 16'h0088;
        req = 4'b0011;
        cyc();
        chk("mid_gnt", 32'(gnt), 32'h1);
        for (int i = 0; i < 4; i++) cyc();
        chk("mid_q4", 32'(Q), 4);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_gnt", 32'(gnt), 0);
        chk("mid_rst_q", 32'(Q), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_done", 32'(done), 0);
        rst = 1'b0;
        cyc();
        chk("restart_gnt", 32'(gnt), 32'h1);
        chk("restart_q", 32'(Q), 0);
        cyc();
        chk("restart_q1", 32'(Q), 1);
        req = '0;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
